// File: rtl/s1_pkg.sv
// Shared definitions for the S1 pipeline memory stage:
// access-size and write-back-source encodings, FSM states, field positions.
package s1_pkg;

  // LSB of the 5-bit destination-register field in the instruction word
  localparam int RD_LSB = 26;

  // Access size, inst[13:12]; 2'd3 behaves as a word
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Write-back source, wb_lines[2:1]; 2'd3 behaves as ALU
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Sizes 2 and 3 are both word accesses
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for the memory stage.
// Ports: size_i/zext_i/addr_i select the lane; store_data_i -> be_o,
// wdata_o (lane-replicated); rdata_i -> load_o (lane-selected, extended).
module mem_align
  import s1_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sext_b;
  logic        sext_h;

  assign byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_lane = addr_i[1] ? rdata_i[31:16]
                               : rdata_i[15:0];
  assign sext_b    = ~zext_i & byte_lane[7];
  assign sext_h    = ~zext_i & half_lane[15];

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    load_o  = rdata_i;
    if (!is_word(size_i)) begin
      if (size_i == SZ_BYTE) begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{store_data_i[7:0]}};
        load_o  = {{24{sext_b}}, byte_lane};
      end else begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
        load_o  = {{16{sext_h}}, half_lane};
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// S1 memory stage: registers execute results, runs load/store over a
// req/ack data bus while stalling upstream, and produces the write-back
// value plus the forwarding triple (forward, rd_addr, write_out).
// Ports: clk/rst (sync, active high), clk_en advance; alu_in, store_data,
// inst_in, ip_in, wb_lines_in, mem_req_in, mem_we_in from execute;
// bus_* data bus; stall, misalign, forward, rd_addr, write_out and
// buffered wb_lines_out/inst_out/ip_out towards write-back.
// Build option: MEM_STAGE_MISALIGN_TRAP_EN flags misaligned half/word
// accesses instead of silently aligning them.
module mem_stage
  import s1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_data,
  input  logic [31:0] inst_in,
  input  logic [29:0] ip_in,
  input  logic [2:0]  wb_lines_in,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        misalign,
  output logic        forward,
  output logic [4:0]  rd_addr,
  output logic [31:0] write_out,
  output logic [2:0]  wb_lines_out,
  output logic [31:0] inst_out,
  output logic [29:0] ip_out
);

  logic [31:0] alu_q;
  logic [31:0] sdata_q;
  logic [31:0] inst_q;
  logic [29:0] ip_q;
  logic [2:0]  wb_q;
  logic        mreq_q;
  logic        mwe_q;
  logic [31:0] load_q;
  logic [31:0] load_d;

  mem_state_t  state_q;
  mem_state_t  state_d;

  logic        done;
  logic        capture;
  logic [1:0]  size;
  logic        mis_cond;
  logic        mis;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_val;

  assign size = inst_q[13:12];

  assign mis_cond = (size == SZ_HALF && alu_q[0])
                  | (is_word(size) && alu_q[1:0] != 2'b00);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign mis  = mreq_q & mis_cond;
  assign addr = alu_q;
`else
  assign mis  = 1'b0;
  // Sub-natural address bits are dropped so the access stays aligned
  assign addr = {alu_q[31:2],
                 alu_q[1] & ~is_word(size),
                 alu_q[0] & (size == SZ_BYTE)};
`endif

  assign done    = (state_q == ST_DONE);
  assign stall   = mreq_q & ~done & ~mis;
  assign bus_req = stall;
  assign capture = clk_en & ~stall;

  mem_align u_align (
    .size_i       (size),
    .zext_i       (inst_q[14]),
    .addr_i       (addr[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (bus_rdata),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_o       (load_val)
  );

  // Bus fields read as zero whenever no request is outstanding
  assign bus_we    = bus_req & mwe_q;
  assign bus_addr  = bus_req ? addr  : 32'd0;
  assign bus_be    = bus_req ? be    : 4'd0;
  assign bus_wdata = bus_req ? wdata : 32'd0;

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    if (bus_req && bus_ack) begin
      load_d = load_val;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          state_d = bus_ack ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_ack) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (capture) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      load_q  <= 32'd0;
      alu_q   <= 32'd0;
      sdata_q <= 32'd0;
      inst_q  <= 32'd0;
      ip_q    <= 30'd0;
      wb_q    <= 3'd0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      if (capture) begin
        alu_q   <= alu_in;
        sdata_q <= store_data;
        inst_q  <= inst_in;
        ip_q    <= ip_in;
        wb_q    <= wb_lines_in;
        mreq_q  <= mem_req_in;
        mwe_q   <= mem_we_in;
      end
    end
  end

  always_comb begin
    unique case (wb_q[2:1])
      WB_LOAD: write_out = load_q;
      WB_LINK: write_out = {ip_q + 30'd1, 2'b00};
      default: write_out = alu_q;
    endcase
  end

  assign misalign     = mis;
  assign forward      = wb_q[0] & ~stall & ~mis;
  assign rd_addr      = inst_q[RD_LSB+4:RD_LSB];
  assign wb_lines_out = {wb_q[2:1], wb_q[0] & ~mis};
  assign inst_out     = inst_q;
  assign ip_out       = ip_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// ops checked against a behavioural model of lanes, stalls and write-back.
module tb_mem_stage;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [31:0] alu_in;
  logic [31:0] store_data;
  logic [31:0] inst_in;
  logic [29:0] ip_in;
  logic [2:0]  wb_lines_in;
  logic        mem_req_in;
  logic        mem_we_in;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic        misalign;
  logic        forward;
  logic [4:0]  rd_addr;
  logic [31:0] write_out;
  logic [2:0]  wb_lines_out;
  logic [31:0] inst_out;
  logic [29:0] ip_out;

  int vectors = 0;
  int miscompares = 0;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .alu_in       (alu_in),
    .store_data   (store_data),
    .inst_in      (inst_in),
    .ip_in        (ip_in),
    .wb_lines_in  (wb_lines_in),
    .mem_req_in   (mem_req_in),
    .mem_we_in    (mem_we_in),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .stall        (stall),
    .misalign     (misalign),
    .forward      (forward),
    .rd_addr      (rd_addr),
    .write_out    (write_out),
    .wb_lines_out (wb_lines_out),
    .inst_out     (inst_out),
    .ip_out       (ip_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations collected by drive_op
  int          o_stall;
  bit          o_req;
  bit          o_stable;
  bit          o_reqeq;
  logic        o_we;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata;
  logic        f_fwd;
  logic        f_mis;
  logic [31:0] f_wo;
  logic [4:0]  f_rd;
  logic [2:0]  f_wbo;
  logic [31:0] f_inst;
  logic [29:0] f_ip;

  // ---------------- reference model ----------------
  function automatic bit m_mis(input logic [1:0] sz,
                               input logic [31:0] a);
    if (sz == 2'd1) return a % 2 != 0;
    if (sz >= 2'd2) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_addr(input logic [1:0] sz,
                                         input logic [31:0] a);
    if (TRAP) return a;
    if (sz == 2'd1) return a - (a % 2);
    if (sz >= 2'd2) return a - (a % 4);
    return a;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz,
                                      input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return (a % 4 >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz,
                                          input logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz,
                                         input bit zx,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (a % 4))) % 256;
      if (!zx && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = (rd >> ((a % 4 >= 2) ? 16 : 0)) % 65536;
      if (!zx && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  // ---------------- stimulus driver ----------------
  task automatic drive_op(input logic [31:0] alu,
                          input logic [31:0] sd,
                          input logic [31:0] inst,
                          input logic [29:0] ip,
                          input logic [2:0]  wb,
                          input bit req, input bit we,
                          input int delay,
                          input logic [31:0] rdata);
    bit fin;
    @(negedge clk);
    alu_in      = alu;
    store_data  = sd;
    inst_in     = inst;
    ip_in       = ip;
    wb_lines_in = wb;
    mem_req_in  = req;
    mem_we_in   = we;
    clk_en      = 1'b1;
    bus_ack     = 1'($urandom_range(0, 1));
    bus_rdata   = $urandom;
    @(posedge clk);
    #1;
    clk_en   = 1'b0;
    bus_ack  = 1'b0;
    o_stall  = 0;
    o_req    = 0;
    o_stable = 1;
    o_reqeq  = 1;
    fin      = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (bus_req !== stall) o_reqeq = 0;
      if (stall === 1'b1) begin
        if (bus_req === 1'b1) begin
          if (!o_req) begin
            o_req   = 1;
            o_we    = bus_we;
            o_addr  = bus_addr;
            o_be    = bus_be;
            o_wdata = bus_wdata;
          end else if (bus_we !== o_we || bus_addr !== o_addr ||
                       bus_be !== o_be || bus_wdata !== o_wdata) begin
            o_stable = 0;
          end
        end
        bus_ack   = (o_stall == delay);
        bus_rdata = bus_ack ? rdata : $urandom;
        // Junk with clk_en=1 while stalled must not be captured
        clk_en     = ~bus_ack;
        alu_in     = $urandom;
        inst_in    = $urandom;
        ip_in      = 30'($urandom);
        wb_lines_in = 3'($urandom);
        mem_req_in = 1'($urandom);
        o_stall++;
      end else begin
        clk_en  = 1'b0;
        bus_ack = 1'($urandom_range(0, 1));
        f_fwd   = forward;
        f_mis   = misalign;
        f_wo    = write_out;
        f_rd    = rd_addr;
        f_wbo   = wb_lines_out;
        f_inst  = inst_out;
        f_ip    = ip_out;
        fin     = 1;
        break;
      end
    end
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL op_timeout stall still %b after 32 cycles", stall);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    clk_en = 1'b1;
    alu_in = $urandom;
    store_data = $urandom;
    inst_in = $urandom;
    ip_in = 30'($urandom);
    wb_lines_in = 3'b111;
    mem_req_in = 1'b1;
    mem_we_in = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus_req, bus_we, stall, forward, misalign} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {bus_req, bus_we, stall, forward, misalign});
    end
    vectors++;
    if (write_out !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_wo got %h exp 0", write_out);
    end
    vectors++;
    if ({bus_addr, bus_be, bus_wdata} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_bus got %h %h %h exp 0",
               bus_addr, bus_be, bus_wdata);
    end
    vectors++;
    if ({rd_addr, wb_lines_out, inst_out, ip_out} !== 70'd0) begin
      miscompares++;
      $display("FAIL reset_bufs got %h %h %h %h exp 0",
               rd_addr, wb_lines_out, inst_out, ip_out);
    end
    rst = 1'b0;
    clk_en = 1'b0;
  endtask

  task automatic test_store_word();
    drive_op(32'h100, 32'hDEADBEEF, 32'h0000_2000, 30'h5,
             3'b000, 1, 1, 2, 32'h0);
    vectors++;
    if (o_stall != 3) begin
      miscompares++;
      $display("FAIL sw_stall got %0d exp 3", o_stall);
    end
    vectors++;
    if ({o_we, o_be} !== 5'b11111) begin
      miscompares++;
      $display("FAIL sw_we_be got %b%b exp 11111", o_we, o_be);
    end
    vectors++;
    if (o_addr !== 32'h100 || o_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL sw_addr_data got %h %h exp 00000100 deadbeef",
               o_addr, o_wdata);
    end
    vectors++;
    if (!o_stable || !o_reqeq) begin
      miscompares++;
      $display("FAIL sw_hold got stable=%0d reqeq=%0d exp 1 1",
               o_stable, o_reqeq);
    end
    vectors++;
    if (f_fwd !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_fwd got %b exp 0", f_fwd);
    end
  endtask

  task automatic test_load_byte();
    drive_op(32'h103, 32'h0, 32'h1400_0000, 30'h7,
             3'b011, 1, 0, 0, 32'h80FF_FFFF);
    vectors++;
    if (o_stall != 1) begin
      miscompares++;
      $display("FAIL lb_stall got %0d exp 1", o_stall);
    end
    vectors++;
    if (f_wo !== 32'hFFFF_FF80 || f_fwd !== 1'b1) begin
      miscompares++;
      $display("FAIL lb_wo got %h fwd %b exp ffffff80 1", f_wo, f_fwd);
    end
    vectors++;
    if (o_be !== 4'b1000 || o_we !== 1'b0 || f_rd !== 5'd5) begin
      miscompares++;
      $display("FAIL lb_be got %b we %b rd %0d exp 1000 0 5",
               o_be, o_we, f_rd);
    end
  endtask

  task automatic test_load_half();
    drive_op(32'h202, 32'h0000_ABCD, 32'h0800_5000, 30'h9,
             3'b011, 1, 0, 1, 32'h8001_1234);
    vectors++;
    if (f_wo !== 32'h0000_8001) begin
      miscompares++;
      $display("FAIL lhu_wo got %h exp 00008001", f_wo);
    end
    vectors++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD) begin
      miscompares++;
      $display("FAIL lhu_lanes got %b %h exp 1100 abcdabcd",
               o_be, o_wdata);
    end
    vectors++;
    if (o_stall != 2) begin
      miscompares++;
      $display("FAIL lhu_stall got %0d exp 2", o_stall);
    end
  endtask

  task automatic test_link();
    drive_op(32'h1234, 32'h0, 32'h0, 30'h10,
             3'b101, 0, 0, 0, 32'h0);
    vectors++;
    if (f_wo !== 32'h44 || f_fwd !== 1'b1) begin
      miscompares++;
      $display("FAIL link_wo got %h fwd %b exp 00000044 1", f_wo, f_fwd);
    end
    vectors++;
    if (o_stall != 0 || o_req) begin
      miscompares++;
      $display("FAIL link_stall got %0d req %0d exp 0 0", o_stall, o_req);
    end
  endtask

  task automatic test_misalign();
    drive_op(32'h101, 32'h0, 32'h0000_2000, 30'h3,
             3'b011, 1, 0, 0, 32'hCAFE_F00D);
    if (TRAP) begin
      vectors++;
      if (f_mis !== 1'b1 || o_req || f_fwd !== 1'b0 || o_stall != 0) begin
        miscompares++;
        $display("FAIL mis_trap got mis %b req %0d fwd %b st %0d exp 1 0 0 0",
                 f_mis, o_req, f_fwd, o_stall);
      end
    end else begin
      vectors++;
      if (o_addr !== 32'h100 || f_mis !== 1'b0 || o_stall != 1) begin
        miscompares++;
        $display("FAIL mis_align got %h mis %b st %0d exp 00000100 0 1",
                 o_addr, f_mis, o_stall);
      end
      vectors++;
      if (f_wo !== 32'hCAFE_F00D || f_fwd !== 1'b1) begin
        miscompares++;
        $display("FAIL mis_align_wo got %h fwd %b exp cafef00d 1",
                 f_wo, f_fwd);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    alu_in = 32'h300;
    inst_in = 32'h0000_2000;
    wb_lines_in = 3'b011;
    mem_req_in = 1'b1;
    mem_we_in = 1'b0;
    clk_en = 1'b1;
    bus_ack = 1'b0;
    @(posedge clk);
    #1 clk_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_req_before got %b exp 1", bus_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h1111_2222;
    vectors++;
    if ({bus_req, stall, forward} !== 3'b000 || write_out !== 32'd0) begin
      miscompares++;
      $display("FAIL rw_after got req %b st %b fwd %b wo %h exp 0 0 0 0",
               bus_req, stall, forward, write_out);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    vectors++;
    if ({bus_req, stall} !== 2'b00 || write_out !== 32'd0) begin
      miscompares++;
      $display("FAIL rw_late_ack got req %b st %b wo %h exp 0 0 0",
               bus_req, stall, write_out);
    end
    drive_op(32'h400, 32'h0, 32'h0000_2000, 30'h0,
             3'b011, 1, 0, 1, 32'h5A5A_A5A5);
    vectors++;
    if (o_stall != 2 || f_wo !== 32'h5A5A_A5A5) begin
      miscompares++;
      $display("FAIL rw_next got st %0d wo %h exp 2 5a5aa5a5",
               o_stall, f_wo);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] alu, sd, inst, rdat, ea, ewo;
      logic [29:0] ip;
      logic [2:0]  wb;
      logic [1:0]  sz, src;
      bit req, we, tmis, acc;
      int dly, est;
      alu  = $urandom;
      if ($urandom_range(0, 1) == 1) alu = alu - (alu % 4);
      sd   = $urandom;
      inst = $urandom;
      ip   = 30'($urandom);
      rdat = $urandom;
      req  = ($urandom_range(0, 2) != 0);
      we   = req && ($urandom_range(0, 1) == 1);
      dly  = $urandom_range(0, 3);
      sz   = inst[13:12];
      if (req && !we) begin
        src = 2'($urandom_range(0, 3));
      end else begin
        src = 2'($urandom_range(0, 2));
        if (src == 2'd1) src = 2'd3;
      end
      wb = {src, 1'($urandom_range(0, 1))};
      drive_op(alu, sd, inst, ip, wb, req, we, dly, rdat);

      tmis = TRAP && req && m_mis(sz, alu);
      acc  = req && !tmis;
      est  = acc ? dly + 1 : 0;
      ea   = m_addr(sz, alu);
      if (src == 2'd1)      ewo = m_load(sz, inst[14], ea, rdat);
      else if (src == 2'd2) ewo = (32'(ip) + 1) * 4;
      else                  ewo = alu;

      vectors++;
      if (o_stall != est || o_req != acc || !o_reqeq) begin
        miscompares++;
        $display("FAIL rnd%0d_stall got %0d req %0d eq %0d exp %0d %0d 1",
                 i, o_stall, o_req, o_reqeq, est, acc);
      end
      if (acc) begin
        vectors++;
        if (o_addr !== ea || o_be !== m_be(sz, ea) ||
            o_wdata !== m_wdata(sz, sd) || o_we !== we || !o_stable) begin
          miscompares++;
          $display("FAIL rnd%0d_bus got %h %b %h %b exp %h %b %h %b",
                   i, o_addr, o_be, o_wdata, o_we,
                   ea, m_be(sz, ea), m_wdata(sz, sd), we);
        end
      end
      if (!tmis) begin
        vectors++;
        if (f_wo !== ewo) begin
          miscompares++;
          $display("FAIL rnd%0d_wo got %h exp %h", i, f_wo, ewo);
        end
      end
      vectors++;
      if (f_fwd !== (wb[0] && !tmis) || f_mis !== tmis) begin
        miscompares++;
        $display("FAIL rnd%0d_fwd got %b mis %b exp %b %b",
                 i, f_fwd, f_mis, wb[0] && !tmis, tmis);
      end
      vectors++;
      if (f_rd !== inst[30:26] || f_inst !== inst || f_ip !== ip ||
          f_wbo !== {wb[2:1], wb[0] && !tmis}) begin
        miscompares++;
        $display("FAIL rnd%0d_bufs got %h %h %h %b exp %h %h %h %b",
                 i, f_rd, f_inst, f_ip, f_wbo,
                 inst[30:26], inst, ip, {wb[2:1], wb[0] && !tmis});
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half();
    test_link();
    test_misalign();
    test_reset_in_wait();
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
